// File: rtl/pc_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage_if
// Bundle of the fetch stage's hazard/redirect controls, the instruction ROM
// bus and the IF/ID pipeline register outputs.
//   master : used by the fetch stage (drives PC, IF/ID, status outputs)
//   slave  : used by the surrounding core / ROM (drives controls, ROM data)
// Signals:
//   Stall, Flush                 hazard controls from later stages
//   BranchTaken/BranchTarget     branch redirect
//   Jump/JumpTarget              j/jal redirect
//   JumpReg/JumpRegTarget        jr redirect
//   RomInstruction               combinational ROM read data for PC
//   PC                           current fetch byte address
//   IFID_Instruction/PCPlus4/Valid  IF/ID pipeline register
//   OutOfRange                   PC beyond the ROM depth (combinational)
//   AlignErr                     one-cycle pulse after a misaligned redirect
//   FetchCount                   saturating count of valid IF/ID loads
// ---------------------------------------------------------------------------
interface pc_fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Stall;
    logic                  Flush;
    logic                  BranchTaken;
    logic [DATA_WIDTH-1:0] BranchTarget;
    logic                  Jump;
    logic [DATA_WIDTH-1:0] JumpTarget;
    logic                  JumpReg;
    logic [DATA_WIDTH-1:0] JumpRegTarget;
    logic [DATA_WIDTH-1:0] RomInstruction;
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] IFID_Instruction;
    logic [DATA_WIDTH-1:0] IFID_PCPlus4;
    logic                  IFID_Valid;
    logic                  OutOfRange;
    logic                  AlignErr;
    logic [DATA_WIDTH-1:0] FetchCount;

    modport master (
        input  Stall, Flush,
        input  BranchTaken, BranchTarget,
        input  Jump, JumpTarget,
        input  JumpReg, JumpRegTarget,
        input  RomInstruction,
        output PC,
        output IFID_Instruction, IFID_PCPlus4, IFID_Valid,
        output OutOfRange, AlignErr, FetchCount
    );

    modport slave (
        output Stall, Flush,
        output BranchTaken, BranchTarget,
        output Jump, JumpTarget,
        output JumpReg, JumpRegTarget,
        output RomInstruction,
        input  PC,
        input  IFID_Instruction, IFID_PCPlus4, IFID_Valid,
        input  OutOfRange, AlignErr, FetchCount
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
// MIPS instruction-fetch stage: program counter, ROM address drive and the
// IF/ID pipeline register, steered by redirect/stall/flush requests.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    pc_fetch_stage_if.master (controls, ROM bus, IF/ID outputs)
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    pc_fetch_stage_if.master   bus
);

    // Clear the byte-offset bits so the PC always points at a word.
    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] ifid_instr_r;
    logic [DATA_WIDTH-1:0] ifid_pcp4_r;
    logic                  ifid_valid_r;
    logic                  align_err_r;
    logic [DATA_WIDTH-1:0] fetch_count_r;

    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic                  out_of_range_s;
    logic                  redirect_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic [DATA_WIDTH-1:0] pc_next_s;
    logic [DATA_WIDTH-1:0] ifid_instr_next_s;
    logic [DATA_WIDTH-1:0] ifid_pcp4_next_s;
    logic                  ifid_valid_next_s;
    logic                  align_err_next_s;
    logic [DATA_WIDTH-1:0] fetch_count_next_s;

    assign pc_plus4_s     = pc_r + DATA_WIDTH'(4);
    // Compare the word index against the ROM depth, zero-extended to full width.
    assign out_of_range_s = ({2'b00, pc_r[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEMORY_DEPTH));
    assign redirect_s     = bus.JumpReg | bus.Jump | bus.BranchTaken;

    // Redirect target selection, highest priority first.
    always_comb begin
        target_s = bus.BranchTarget;
        if (bus.JumpReg) begin
            target_s = bus.JumpRegTarget;
        end else if (bus.Jump) begin
            target_s = bus.JumpTarget;
        end else begin
            target_s = bus.BranchTarget;
        end
    end

    // Next PC, IF/ID contents, alignment flag and fetch counter.
    always_comb begin
        pc_next_s          = pc_r;
        ifid_instr_next_s  = ifid_instr_r;
        ifid_pcp4_next_s   = ifid_pcp4_r;
        ifid_valid_next_s  = ifid_valid_r;
        align_err_next_s   = 1'b0;
        fetch_count_next_s = fetch_count_r;
        if (redirect_s) begin
            // Redirect wins over stall and flush; the wrong-path fetch is dropped.
            pc_next_s         = word_align(target_s);
            ifid_instr_next_s = NOP_WORD;
            ifid_pcp4_next_s  = '0;
            ifid_valid_next_s = 1'b0;
            align_err_next_s  = (target_s[1:0] != 2'b00);
        end else if (bus.Stall && bus.Flush) begin
            ifid_instr_next_s = NOP_WORD;
            ifid_pcp4_next_s  = '0;
            ifid_valid_next_s = 1'b0;
        end else if (bus.Stall) begin
            pc_next_s = pc_r;
        end else if (bus.Flush) begin
            pc_next_s         = pc_plus4_s;
            ifid_instr_next_s = NOP_WORD;
            ifid_pcp4_next_s  = '0;
            ifid_valid_next_s = 1'b0;
        end else begin
            pc_next_s = pc_plus4_s;
            if (out_of_range_s) begin
                // Nothing real lives past the ROM; keep advancing but insert a bubble.
                ifid_instr_next_s = NOP_WORD;
                ifid_pcp4_next_s  = '0;
                ifid_valid_next_s = 1'b0;
            end else begin
                ifid_instr_next_s = bus.RomInstruction;
                ifid_pcp4_next_s  = pc_plus4_s;
                ifid_valid_next_s = 1'b1;
                if (fetch_count_r != '1) begin
                    fetch_count_next_s = fetch_count_r + DATA_WIDTH'(1);
                end else begin
                    fetch_count_next_s = fetch_count_r;
                end
            end
        end
    end

    // PC, IF/ID register and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_PC;
            ifid_instr_r  <= NOP_WORD;
            ifid_pcp4_r   <= '0;
            ifid_valid_r  <= 1'b0;
            align_err_r   <= 1'b0;
            fetch_count_r <= '0;
        end else begin
            pc_r          <= pc_next_s;
            ifid_instr_r  <= ifid_instr_next_s;
            ifid_pcp4_r   <= ifid_pcp4_next_s;
            ifid_valid_r  <= ifid_valid_next_s;
            align_err_r   <= align_err_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    assign bus.PC               = pc_r;
    assign bus.IFID_Instruction = ifid_instr_r;
    assign bus.IFID_PCPlus4     = ifid_pcp4_r;
    assign bus.IFID_Valid       = ifid_valid_r;
    assign bus.AlignErr         = align_err_r;
    assign bus.FetchCount       = fetch_count_r;
    assign bus.OutOfRange       = out_of_range_s;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_stage
// Directed, table-driven bench for pc_fetch_stage. The ROM returns
// 32'h1000_0000 + word index for any PC. Each table row holds the controls
// applied for one cycle and the hand-computed register state after the edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_stage;

    localparam int DW = 32;

    logic clk;
    logic reset;

    pc_fetch_stage_if #(.DATA_WIDTH(DW)) bus ();

    pc_fetch_stage #(
        .DATA_WIDTH  (DW),
        .MEMORY_DEPTH(32),
        .RESET_PC    (32'h0000_0000),
        .NOP_WORD    (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM model: word k holds 32'h1000_0000 + k.
    always_comb bus.RomInstruction = 32'h1000_0000 + {2'b00, bus.PC[DW-1:2]};

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pcp4;
        logic        e_valid;
        logic        e_align;
        logic [31:0] e_count;
        logic        e_oor;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(
        input logic s, input logic f,
        input logic br, input logic [31:0] brt,
        input logic j,  input logic [31:0] jt,
        input logic jr, input logic [31:0] jrt,
        input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4,
        input logic v, input logic a, input logic [31:0] c, input logic o);
        vec_t r;
        r.stall = s; r.flush = f; r.br = br; r.brt = brt; r.j = j; r.jt = jt;
        r.jr = jr; r.jrt = jrt; r.e_pc = pc; r.e_instr = ins; r.e_pcp4 = p4;
        r.e_valid = v; r.e_align = a; r.e_count = c; r.e_oor = o;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] p4, input logic v, input logic a,
                               input logic [31:0] c, input logic o);
        check({tag, " PC"},          bus.PC, pc);
        check({tag, " IFID_Instr"},  bus.IFID_Instruction, ins);
        check({tag, " IFID_PCP4"},   bus.IFID_PCPlus4, p4);
        check({tag, " IFID_Valid"},  {31'd0, bus.IFID_Valid}, {31'd0, v});
        check({tag, " AlignErr"},    {31'd0, bus.AlignErr}, {31'd0, a});
        check({tag, " FetchCount"},  bus.FetchCount, c);
        check({tag, " OutOfRange"},  {31'd0, bus.OutOfRange}, {31'd0, o});
    endtask

    task automatic drive_idle();
        bus.Stall = 1'b0; bus.Flush = 1'b0;
        bus.BranchTaken = 1'b0; bus.BranchTarget = 32'h0;
        bus.Jump = 1'b0; bus.JumpTarget = 32'h0;
        bus.JumpReg = 1'b0; bus.JumpRegTarget = 32'h0;
    endtask

    initial begin
        //                 S     F     BR    BRT           J     JT            JR    JRT           PC            INSTR         PCP4          V     A     CNT    OOR
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 1'b0, 32'd1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 1'b0, 32'd2, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 1'b0, 32'd2, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 1'b0, 32'd2, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        32'h1000_0002, 32'hC,       1'b1, 1'b0, 32'd3, 1'b0);
        // Branch and jump together: jump wins.
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'h20,       1'b0, 32'h0,        32'h20,       32'h0,         32'h0,       1'b0, 1'b0, 32'd3, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h24,       32'h1000_0008, 32'h24,      1'b1, 1'b0, 32'd4, 1'b0);
        // Misaligned jr plus stall and a lower-priority branch: jr wins, stall ignored.
        vecs[7]  = mk(1'b1, 1'b0, 1'b1, 32'h41,       1'b0, 32'h0,        1'b1, 32'h46,       32'h44,       32'h0,         32'h0,       1'b0, 1'b1, 32'd4, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h48,       32'h1000_0011, 32'h48,      1'b1, 1'b0, 32'd5, 1'b0);
        // Aligned jump with an unselected misaligned branch target: no AlignErr.
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h3,        1'b1, 32'h7C,       1'b0, 32'h0,        32'h7C,       32'h0,         32'h0,       1'b0, 1'b0, 32'd5, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h80,       32'h1000_001F, 32'h80,      1'b1, 1'b0, 32'd6, 1'b1);
        // Fetch at 0x80 is past the ROM: bubble, count unchanged, PC advances.
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h84,       32'h0,         32'h0,       1'b0, 1'b0, 32'd6, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,         32'h0,       1'b0, 1'b0, 32'd6, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 1'b0, 32'd7, 1'b0);
        // Flush alone: PC advances, bubble.
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        32'h0,         32'h0,       1'b0, 1'b0, 32'd7, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        32'h1000_0002, 32'hC,       1'b1, 1'b0, 32'd8, 1'b0);
        // Stall and flush: PC held, bubble.
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        32'h0,         32'h0,       1'b0, 1'b0, 32'd8, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h10,       32'h1000_0003, 32'h10,      1'b1, 1'b0, 32'd9, 1'b0);
        // jr to 0xFFFF_FFFF aligns to 0xFFFF_FFFC, then PC wraps to zero.
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,       32'h0,       1'b0, 1'b1, 32'd9, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,         32'h0,       1'b0, 1'b0, 32'd9, 1'b0);

        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.Stall         = vecs[i].stall;
            bus.Flush         = vecs[i].flush;
            bus.BranchTaken   = vecs[i].br;
            bus.BranchTarget  = vecs[i].brt;
            bus.Jump          = vecs[i].j;
            bus.JumpTarget    = vecs[i].jt;
            bus.JumpReg       = vecs[i].jr;
            bus.JumpRegTarget = vecs[i].jrt;
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcp4,
                        vecs[i].e_valid, vecs[i].e_align, vecs[i].e_count, vecs[i].e_oor);
            @(negedge clk);
        end

        // Build up state again, then assert reset between edges while stalled.
        drive_idle();
        repeat (2) @(negedge clk);
        bus.Stall = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check_state("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        reset = 1'b1;
        bus.Stall = 1'b0;
        @(posedge clk);
        #1;
        check_state("post_rst", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 1'b0, 32'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
